// File: rtl/bp_be_pkg.sv
// Shared backend package: sizing helpers for the FE-to-BE queue.
// Entry contents stay opaque here; only pointer geometry is described.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_FE_QUEUE_PTR_WIDTH(els) ($clog2(els)+1)

package bp_be_pkg;

    // Pointer width carries one extra wrap bit so full and empty differ.
    function automatic int fe_queue_ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    function automatic int fe_queue_deq_cnt_width(input int deq_max);
        return $clog2(deq_max + 1);
    endfunction

endpackage

`endif

// File: rtl/bp_be_fe_queue_mem.sv
// FE queue storage: flop array with one write port and one asynchronous read.
module bp_be_fe_queue_mem #(
    parameter int width_p = 64,
    parameter int els_p   = 16,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // NOTE: storage has no reset; pointers alone decide which slots are valid.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_rollback.sv
// Checkpointing FE-to-BE queue: speculative read pointer, multi-entry retire,
// rollback to the oldest unretired entry, and flush.
module bp_be_fe_queue_rollback
    import bp_be_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int els_p     = 16,
    parameter int deq_max_p = 2,
    localparam int lg_els_lp        = $clog2(els_p),
    localparam int ptr_width_lp     = fe_queue_ptr_width(els_p),
    localparam int deq_cnt_width_lp = fe_queue_deq_cnt_width(deq_max_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [width_p-1:0]          data_i,
    input  logic                        v_i,
    output logic                        ready_o,

    output logic [width_p-1:0]          data_o,
    output logic                        v_o,
    input  logic                        yumi_i,

    input  logic [deq_cnt_width_lp-1:0] deq_cnt_i,
    input  logic                        roll_i,
    input  logic                        clr_i,

    output logic [ptr_width_lp-1:0]     unretired_cnt_o,
    output logic [ptr_width_lp-1:0]     free_cnt_o
);

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_width_lp-1:0] wptr_d, rptr_d, cptr_d;
    logic [ptr_width_lp-1:0] occupancy;
    logic                    full, read_empty, enq, consume;

    // Occupancy counts from the checkpoint: unretired entries still hold slots.
    assign occupancy  = wptr_r - cptr_r;
    assign full       = (occupancy == ptr_width_lp'(els_p));
    assign read_empty = (rptr_r == wptr_r);

    assign ready_o         = ~full;
    assign v_o             = ~read_empty;
    assign unretired_cnt_o = rptr_r - cptr_r;
    assign free_cnt_o      = ptr_width_lp'(els_p) - occupancy;

    assign enq     = v_i & ready_o;
    assign consume = yumi_i & v_o;

    assign wptr_n = wptr_r + ptr_width_lp'(enq);
    assign rptr_n = rptr_r + ptr_width_lp'(consume);
    assign cptr_n = cptr_r + ptr_width_lp'(deq_cnt_i);

    // NOTE: every output gets a default first, so no branch can leave a latch.
    always_comb begin
        wptr_d = wptr_n;
        rptr_d = rptr_n;
        cptr_d = cptr_n;
        if (clr_i) begin
            rptr_d = wptr_n;
            cptr_d = wptr_n;
        end else if (roll_i) begin
            // Retire lands first, then the read pointer rewinds onto it.
            rptr_d = cptr_n;
        end
    end

    // NOTE: state uses non-blocking assignments so all pointers update together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_d;
            rptr_r <= rptr_d;
            cptr_r <= cptr_d;
        end
    end

    // A slot written during a clear is discarded by the pointer update anyway.
    bp_be_fe_queue_mem #(
        .width_p (width_p),
        .els_p   (els_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_r[lg_els_lp-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr_r[lg_els_lp-1:0]),
        .r_data_o (data_o)
    );

    // Illegal checker behaviour is flagged, never repaired.
    deq_within_unretired: assert property (@(posedge clk_i) disable iff (reset_i)
        !clr_i |-> (ptr_width_lp'(deq_cnt_i) <= unretired_cnt_o));

    deq_within_bandwidth: assert property (@(posedge clk_i) disable iff (reset_i)
        deq_cnt_i <= deq_cnt_width_lp'(deq_max_p));

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !clr_i |-> !(yumi_i && !v_o));

endmodule

// File: tb/tb_bp_be_fe_queue_rollback.sv
// Directed bench for the rollback FE queue with els_p=8, width_p=16, deq_max_p=2.
module tb_bp_be_fe_queue_rollback;

    localparam int width_p   = 16;
    localparam int els_p     = 8;
    localparam int deq_max_p = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] data_i;
    logic        v_i;
    logic        ready_o;
    logic [15:0] data_o;
    logic        v_o;
    logic        yumi_i;
    logic [1:0]  deq_cnt_i;
    logic        roll_i;
    logic        clr_i;
    logic [3:0]  unretired_cnt_o;
    logic [3:0]  free_cnt_o;

    int checks = 0;
    int errors = 0;

    bp_be_fe_queue_rollback #(
        .width_p   (width_p),
        .els_p     (els_p),
        .deq_max_p (deq_max_p)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .data_i          (data_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .v_o             (v_o),
        .yumi_i          (yumi_i),
        .deq_cnt_i       (deq_cnt_i),
        .roll_i          (roll_i),
        .clr_i           (clr_i),
        .unretired_cnt_o (unretired_cnt_o),
        .free_cnt_o      (free_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge and settle 1 time unit past it before sampling.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        v_i       = 1'b0;
        data_i    = '0;
        yumi_i    = 1'b0;
        deq_cnt_i = '0;
        roll_i    = 1'b0;
        clr_i     = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        idle();
        reset_i = 1'b1;
        repeat (n) cycle();
        reset_i = 1'b0;
    endtask

    task automatic enqueue(input logic [15:0] d);
        v_i = 1'b1;
        data_i = d;
        cycle();
        v_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%0h required=1", ready_o); end
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v actual=%0h required=0", v_o); end
        checks++; if (free_cnt_o !== 4'd8) begin errors++; $display("FAIL reset_free actual=%0d required=8", free_cnt_o); end
        checks++; if (unretired_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_unretired actual=%0d required=0", unretired_cnt_o); end
    endtask

    task automatic test_fill_retire();
        apply_reset(1);
        for (int i = 0; i < 8; i++) enqueue(16'(i));
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready actual=%0h required=0", ready_o); end
        checks++; if (free_cnt_o !== 4'd0) begin errors++; $display("FAIL fill_free actual=%0d required=0", free_cnt_o); end
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0000) begin errors++; $display("FAIL fill_head actual=%0h/%0h required=1/0", v_o, data_o); end
        enqueue(16'hFFFF);
        checks++; if (free_cnt_o !== 4'd0) begin errors++; $display("FAIL full_refused_free actual=%0d required=0", free_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_o !== 16'(i)) begin errors++; $display("FAIL fill_yumi_data actual=%0h required=%0h", data_o, i); end
            yumi_i = 1'b1;
            cycle();
        end
        yumi_i = 1'b0;
        checks++; if (unretired_cnt_o !== 4'd3) begin errors++; $display("FAIL yumi3_unretired actual=%0d required=3", unretired_cnt_o); end
        checks++; if (free_cnt_o !== 4'd0) begin errors++; $display("FAIL yumi3_free actual=%0d required=0", free_cnt_o); end
        checks++; if (data_o !== 16'h0003) begin errors++; $display("FAIL yumi3_data actual=%0h required=3", data_o); end
        deq_cnt_i = 2'd2;
        cycle();
        deq_cnt_i = 2'd0;
        checks++; if (free_cnt_o !== 4'd2) begin errors++; $display("FAIL retire_free actual=%0d required=2", free_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL retire_ready actual=%0h required=1", ready_o); end
        checks++; if (unretired_cnt_o !== 4'd1) begin errors++; $display("FAIL retire_unretired actual=%0d required=1", unretired_cnt_o); end
    endtask

    task automatic test_roll_retire();
        apply_reset(1);
        enqueue(16'h000A);
        enqueue(16'h000B);
        enqueue(16'h000C);
        enqueue(16'h000D);
        for (int i = 0; i < 3; i++) begin
            yumi_i = 1'b1;
            cycle();
        end
        yumi_i = 1'b0;
        checks++; if (unretired_cnt_o !== 4'd3 || data_o !== 16'h000D) begin errors++; $display("FAIL roll_pre actual=%0d/%0h required=3/d", unretired_cnt_o, data_o); end
        deq_cnt_i = 2'd1;
        roll_i    = 1'b1;
        yumi_i    = 1'b1;
        cycle();
        idle();
        checks++; if (data_o !== 16'h000B) begin errors++; $display("FAIL roll_data actual=%0h required=b", data_o); end
        checks++; if (unretired_cnt_o !== 4'd0) begin errors++; $display("FAIL roll_unretired actual=%0d required=0", unretired_cnt_o); end
        checks++; if (free_cnt_o !== 4'd5) begin errors++; $display("FAIL roll_free actual=%0d required=5", free_cnt_o); end
        yumi_i = 1'b1;
        cycle();
        yumi_i = 1'b0;
        checks++; if (data_o !== 16'h000C) begin errors++; $display("FAIL roll_next actual=%0h required=c", data_o); end
    endtask

    task automatic test_clear_enq();
        apply_reset(1);
        for (int i = 0; i < 5; i++) enqueue(16'(16'h20 + i));
        yumi_i = 1'b1;
        cycle();
        cycle();
        yumi_i = 1'b0;
        clr_i  = 1'b1;
        v_i    = 1'b1;
        data_i = 16'h0077;
        cycle();
        idle();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL clr_v actual=%0h required=0", v_o); end
        checks++; if (free_cnt_o !== 4'd8) begin errors++; $display("FAIL clr_free actual=%0d required=8", free_cnt_o); end
        checks++; if (unretired_cnt_o !== 4'd0) begin errors++; $display("FAIL clr_unretired actual=%0d required=0", unretired_cnt_o); end
        enqueue(16'h0055);
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0055) begin errors++; $display("FAIL clr_next actual=%0h/%0h required=1/55", v_o, data_o); end
    endtask

    task automatic test_wrap();
        int  w, r, c;
        bit  do_y, do_d;
        bit  done;
        apply_reset(1);
        w = 0; r = 0; c = 0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            checks++; if (free_cnt_o !== 4'(8 - (w - c)) || free_cnt_o < 4'd6) begin errors++; $display("FAIL wrap_free cycle=%0d actual=%0d required=%0d", k, free_cnt_o, 8 - (w - c)); end
            do_y = (r < w);
            do_d = (r > c);
            if (do_y) begin
                checks++; if (data_o !== 16'(16'h10 + r)) begin errors++; $display("FAIL wrap_data idx=%0d actual=%0h required=%0h", r, data_o, 16'h10 + r); end
            end
            v_i       = (w < 20);
            data_i    = 16'(16'h10 + w);
            yumi_i    = do_y;
            deq_cnt_i = do_d ? 2'd1 : 2'd0;
            cycle();
            if (w < 20) w++;
            if (do_y) r++;
            if (do_d) c++;
            done = (r == 20) && (c == 20);
        end
        idle();
        if (!done) begin errors++; $display("FAIL wrap_timeout actual=r%0d/c%0d required=20/20", r, c); end
        checks++; if (v_o !== 1'b0 || free_cnt_o !== 4'd8) begin errors++; $display("FAIL wrap_drained actual=%0h/%0d required=0/8", v_o, free_cnt_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset(1);
        for (int i = 0; i < 7; i++) enqueue(16'(16'h30 + i));
        yumi_i = 1'b1;
        repeat (4) cycle();
        yumi_i = 1'b0;
        checks++; if (unretired_cnt_o !== 4'd4 || data_o !== 16'h0034) begin errors++; $display("FAIL mid_pre actual=%0d/%0h required=4/34", unretired_cnt_o, data_o); end
        apply_reset(1);
        checks++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL mid_flags actual=%0h/%0h required=1/0", ready_o, v_o); end
        checks++; if (free_cnt_o !== 4'd8 || unretired_cnt_o !== 4'd0) begin errors++; $display("FAIL mid_counts actual=%0d/%0d required=8/0", free_cnt_o, unretired_cnt_o); end
        enqueue(16'h0099);
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0099) begin errors++; $display("FAIL mid_next actual=%0h/%0h required=1/99", v_o, data_o); end
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        test_reset();
        test_fill_retire();
        test_roll_retire();
        test_clear_enq();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
